// File: rtl/risc16_ctrl.sv
// Multi-cycle control unit for the RiSC-16 core: owns PC/IR, sequences
// FETCH/DECODE/EXEC/MEM and drives ALU strobes, RF addressing and memory requests.
module risc16_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack,
   input  logic [15:0] alu_out,
   input  logic        eq_out,
   output logic [15:0] pc,
   output logic [15:0] ir,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic        ADD,
   output logic        NAND,
   output logic        PASS1,
   output logic        EQ,
   output logic        src1_sel,
   output logic        src2_sel,
   output logic [2:0]  rf_raddr1,
   output logic [2:0]  rf_raddr2,
   output logic        rf_we,
   output logic [2:0]  rf_waddr,
   output logic [1:0]  rf_wdata_sel,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_DECODE = 2'd1,
      S_EXEC   = 2'd2,
      S_MEM    = 2'd3
   } state_t;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_ADDI = 3'd1;
   localparam logic [2:0] OP_NAND = 3'd2;
   localparam logic [2:0] OP_LUI  = 3'd3;
   localparam logic [2:0] OP_SW   = 3'd4;
   localparam logic [2:0] OP_LW   = 3'd5;
   localparam logic [2:0] OP_BEQ  = 3'd6;
   localparam logic [2:0] OP_JALR = 3'd7;

   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] ir_q, ir_d;
   logic [2:0]  op, ra, rb, rc;
   logic [15:0] simm_ext;
   logic        wr_ok;

   assign op       = ir_q[15:13];
   assign ra       = ir_q[12:10];
   assign rb       = ir_q[9:7];
   assign rc       = ir_q[2:0];
   assign simm_ext = {{9{ir_q[6]}}, ir_q[6:0]};
   // r0 is hardwired zero, so any write targeting it is suppressed
   assign wr_ok    = (ra != 3'd0);

   assign pc       = pc_q;
   assign ir       = ir_q;
   assign state    = state_q;
   assign rf_waddr = ra;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ir_d         = ir_q;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = pc_q;
      ADD          = 1'b0;
      NAND         = 1'b0;
      PASS1        = 1'b0;
      EQ           = 1'b0;
      src1_sel     = 1'b0;
      src2_sel     = 1'b0;
      rf_we        = 1'b0;
      rf_wdata_sel = 2'd0;
      rf_raddr1    = rb;
      rf_raddr2    = rc;

      if (op == OP_BEQ) begin
         rf_raddr1 = ra;
         rf_raddr2 = rb;
      end else if (op == OP_SW) begin
         rf_raddr1 = rb;
         rf_raddr2 = ra;
      end

      unique case (state_q)
         S_FETCH: begin
            // state_q already reads FETCH while rst is high; keep the request quiet
            mem_req = ~rst;
            if (mem_ack) begin
               ir_d    = mem_rdata;
               pc_d    = pc_q + 16'd1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            state_d = S_FETCH;
            unique case (op)
               OP_ADD:  begin ADD = 1'b1; rf_we = wr_ok; end
               OP_ADDI: begin ADD = 1'b1; src2_sel = 1'b1; rf_we = wr_ok; end
               OP_NAND: begin NAND = 1'b1; rf_we = wr_ok; end
               OP_LUI:  begin PASS1 = 1'b1; src1_sel = 1'b1; rf_we = wr_ok; end
               OP_BEQ: begin
                  EQ = 1'b1;
                  if (eq_out) pc_d = pc_q + simm_ext;
               end
               OP_JALR: begin
                  // link value is the already-incremented pc, taken before this edge
                  PASS1        = 1'b1;
                  rf_we        = wr_ok;
                  rf_wdata_sel = wr_ok ? 2'd2 : 2'd0;
                  pc_d         = alu_out;
               end
               default: begin
                  ADD      = 1'b1;
                  src2_sel = 1'b1;
                  state_d  = S_MEM;
               end
            endcase
         end
         S_MEM: begin
            ADD      = 1'b1;
            src2_sel = 1'b1;
            mem_req  = 1'b1;
            mem_addr = alu_out;
            mem_we   = (op == OP_SW);
            if (mem_ack) begin
               state_d = S_FETCH;
               if (op == OP_LW && wr_ok) begin
                  rf_we        = 1'b1;
                  rf_wdata_sel = 2'd1;
               end
            end
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= 16'd0;
         ir_q    <= 16'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

endmodule

// File: tb/tb_risc16_ctrl.sv
// Directed bench for risc16_ctrl: walks through ALU, branch, jump, load/store
// and reset-abort sequences with hand-computed expectations.
module tb_risc16_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] mem_rdata;
   logic        mem_ack;
   logic [15:0] alu_out;
   logic        eq_out;
   logic [15:0] pc, ir, mem_addr;
   logic        mem_req, mem_we, ADD, NAND, PASS1, EQ, src1_sel, src2_sel, rf_we;
   logic [2:0]  rf_raddr1, rf_raddr2, rf_waddr;
   logic [1:0]  rf_wdata_sel, state;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   risc16_ctrl dut (
      .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .alu_out(alu_out), .eq_out(eq_out), .pc(pc), .ir(ir),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .ADD(ADD), .NAND(NAND), .PASS1(PASS1), .EQ(EQ),
      .src1_sel(src1_sel), .src2_sel(src2_sel),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata_sel(rf_wdata_sel),
      .state(state)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Presents instr with an immediate ack in FETCH and returns once EXEC is reached.
   task automatic do_fetch(input logic [15:0] instr);
      mem_rdata = instr;
      mem_ack   = 1'b1;
      step();
      mem_ack   = 1'b0;
      step();
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; mem_ack = 1'b0; mem_rdata = 16'h0; alu_out = 16'h0; eq_out = 1'b0;
      step(); step();
      mem_ack = 1'b1; mem_rdata = 16'h2405; #1;
      chk("rst_state", state, 16'd0);
      chk("rst_pc", pc, 16'd0);
      chk("rst_ir", ir, 16'd0);
      chk("rst_req", mem_req, 16'd0);
      mem_ack = 1'b0;
      step();

      // ADDI r1,r0,5
      rst = 1'b0; mem_rdata = 16'h2405; mem_ack = 1'b1; #1;
      chk("f_state", state, 16'd0);
      chk("f_req", mem_req, 16'd1);
      chk("f_addr", mem_addr, 16'h0000);
      chk("f_we", mem_we, 16'd0);
      step(); mem_ack = 1'b0; #1;
      chk("d_state", state, 16'd1);
      chk("d_ir", ir, 16'h2405);
      chk("d_pc", pc, 16'd1);
      chk("d_req", mem_req, 16'd0);
      chk("d_add", ADD, 16'd0);
      step(); #1;
      chk("e_state", state, 16'd2);
      chk("e_add", ADD, 16'd1);
      chk("e_src2", src2_sel, 16'd1);
      chk("e_we", rf_we, 16'd1);
      chk("e_waddr", rf_waddr, 16'd1);
      chk("e_wsel", rf_wdata_sel, 16'd0);
      step(); #1;
      chk("addi_ret", state, 16'd0);
      chk("addi_pc", pc, 16'd1);

      // JALR r0,r0 to 5: no link write
      do_fetch(16'hE000); alu_out = 16'h0005; #1;
      chk("j0_pass", PASS1, 16'd1);
      chk("j0_we", rf_we, 16'd0);
      step(); #1;
      chk("j0_pc", pc, 16'h0005);

      // BEQ r0,r0,-2 taken then not taken
      do_fetch(16'hC07E); eq_out = 1'b1; #1;
      chk("beq_eq", EQ, 16'd1);
      chk("beq_src2", src2_sel, 16'd0);
      chk("beq_pc_pre", pc, 16'h0006);
      chk("beq_we", rf_we, 16'd0);
      step(); #1;
      chk("beq_taken", pc, 16'h0004);
      eq_out = 1'b0;
      do_fetch(16'hC07E); #1;
      step(); #1;
      chk("beq_not", pc, 16'h0005);

      // LW r1,1(r1): one fetch wait, three MEM waits
      mem_rdata = 16'hA481; mem_ack = 1'b0; #1;
      chk("fw_req", mem_req, 16'd1);
      step(); #1;
      chk("fw_state", state, 16'd0);
      chk("fw_pc", pc, 16'h0005);
      do_fetch(16'hA481); alu_out = 16'h0042; #1;
      chk("lw_e_add", ADD, 16'd1);
      chk("lw_e_src2", src2_sel, 16'd1);
      chk("lw_e_req", mem_req, 16'd0);
      chk("lw_e_raddr1", rf_raddr1, 16'd1);
      step(); #1;
      chk("lw_m_state", state, 16'd3);
      chk("lw_m_req", mem_req, 16'd1);
      chk("lw_m_addr", mem_addr, 16'h0042);
      chk("lw_m_we", mem_we, 16'd0);
      chk("lw_m_rfwe", rf_we, 16'd0);
      step(); step(); #1;
      chk("lw_w3_req", mem_req, 16'd1);
      chk("lw_w3_addr", mem_addr, 16'h0042);
      chk("lw_w3_rfwe", rf_we, 16'd0);
      step(); mem_ack = 1'b1; #1;
      chk("lw_ack_state", state, 16'd3);
      chk("lw_ack_rfwe", rf_we, 16'd1);
      chk("lw_ack_wsel", rf_wdata_sel, 16'd1);
      chk("lw_ack_waddr", rf_waddr, 16'd1);
      step(); mem_ack = 1'b0; #1;
      chk("lw_ret", state, 16'd0);
      chk("lw_ret_addr", mem_addr, 16'h0006);
      chk("lw_ret_rfwe", rf_we, 16'd0);

      // JALR to 0x10, then JALR r7,r2
      do_fetch(16'hE000); alu_out = 16'h0010;
      step(); #1;
      chk("j1_pc", pc, 16'h0010);
      do_fetch(16'hFD00); alu_out = 16'h0100; #1;
      chk("jalr_pass", PASS1, 16'd1);
      chk("jalr_src1", src1_sel, 16'd0);
      chk("jalr_raddr1", rf_raddr1, 16'd2);
      chk("jalr_we", rf_we, 16'd1);
      chk("jalr_waddr", rf_waddr, 16'd7);
      chk("jalr_wsel", rf_wdata_sel, 16'd2);
      chk("jalr_link", pc, 16'h0011);
      step(); #1;
      chk("jalr_pc", pc, 16'h0100);

      // ADD r0,r1,r2
      do_fetch(16'h0082); #1;
      chk("add0_add", ADD, 16'd1);
      chk("add0_we", rf_we, 16'd0);
      chk("add0_ra1", rf_raddr1, 16'd1);
      chk("add0_ra2", rf_raddr2, 16'd2);
      step();

      // SW r3,3(r5) aborted by reset in MEM
      do_fetch(16'h8E83); alu_out = 16'h0200; #1;
      chk("sw_ra1", rf_raddr1, 16'd5);
      chk("sw_ra2", rf_raddr2, 16'd3);
      chk("sw_pc", pc, 16'h0102);
      step(); #1;
      chk("sw_m_state", state, 16'd3);
      chk("sw_m_we", mem_we, 16'd1);
      chk("sw_m_addr", mem_addr, 16'h0200);
      rst = 1'b1; #1;
      chk("abort_req", mem_req, 16'd0);
      chk("abort_we", mem_we, 16'd0);
      chk("abort_state", state, 16'd0);
      chk("abort_pc", pc, 16'd0);
      chk("abort_addr", mem_addr, 16'd0);
      chk("abort_add", ADD, 16'd0);
      chk("abort_src2", src2_sel, 16'd0);
      step(); step();
      rst = 1'b0; #1;
      chk("post_req", mem_req, 16'd1);
      chk("post_addr", mem_addr, 16'd0);
      chk("post_ir", ir, 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
